memory_data_be: RTL and testbench

- Parametrised successor of the single-port data memory: one write port and one read port on the same clock, with per-byte write enables and write-first forwarding.
- Hardwired-zero location at address 0 (optional), out-of-range detection, and a built-in sequential clear engine that zeroes the array after reset or on request.
- Sits in the datapath as the data/register store behind the load/store unit.

---
 rtl/memory_data_be_if.sv | 20 ++
 rtl/memory_data_be.sv | 68 ++++++
 tb/tb_memory_data_be.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_data_be_if.sv
// memory_data_be_if: port bundle for the byte-enable data memory.
interface memory_data_be_if #(
    parameter int A = 7,
    parameter int D = 8
);
    localparam int NB = D / 8;
    logic          clr;
    logic          we;
    logic [A-1:0]  waddr;
    logic [D-1:0]  wdata;
    logic [NB-1:0] wbe;
    logic          re;
    logic [A-1:0]  raddr;
    logic [D-1:0]  q;
    logic          rvalid;
    logic          busy;
    logic          err;
    modport master(output clr, we, waddr, wdata, wbe, re, raddr, input q, rvalid, busy, err);
    modport slave(input clr, we, waddr, wdata, wbe, re, raddr, output q, rvalid, busy, err);
endinterface

// File: rtl/memory_data_be.sv
// memory_data_be: 1W/1R byte-enable memory with write-first forwarding,
// optional hardwired-zero address 0, range checking and a sequential clear engine.
module memory_data_be #(
    parameter int A       = 7,
    parameter int D       = 8,
    parameter int R       = 128,
    parameter bit ZERO_EN = 1'b1,
    localparam int NB     = D / 8
) (
    input logic             clk,
    input logic             rst,
    memory_data_be_if.slave bus
);
    typedef enum logic {CLEAR, IDLE} state_t;
    localparam logic [A:0]   R_LIM = (A + 1)'(R);
    localparam logic [A-1:0] LAST  = A'(R - 1);

    state_t       state;
    logic [A-1:0] cnt;
    logic [D-1:0] mem [R];
    logic [D-1:0] merged;
    logic [D-1:0] rdata;
    logic         idle, wacc, racc, w_in, r_in, wok, rzero;

    assign idle  = state == IDLE;
    assign wacc  = idle && bus.we;
    assign racc  = idle && bus.re;
    assign w_in  = {1'b0, bus.waddr} < R_LIM;
    assign r_in  = {1'b0, bus.raddr} < R_LIM;
    assign wok   = wacc && w_in && !(ZERO_EN && bus.waddr == '0);
    assign rzero = !r_in || (ZERO_EN && bus.raddr == '0);
    assign bus.busy = !idle;

    // Merged word is both what gets stored and what a same-address read forwards.
    always_comb begin
        merged = mem[bus.waddr];
        for (int i = 0; i < NB; i++)
            if (bus.wbe[i]) merged[8*i +: 8] = bus.wdata[8*i +: 8];
    end

    assign rdata = rzero ? '0 : (wok && bus.raddr == bus.waddr) ? merged : mem[bus.raddr];

    always_ff @(posedge clk) begin
        if (!idle) mem[cnt] <= '0;
        else if (wok) mem[bus.waddr] <= merged;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= CLEAR;
            cnt        <= '0;
            bus.q      <= '0;
            bus.rvalid <= 1'b0;
            bus.err    <= 1'b0;
        end else begin
            bus.rvalid <= racc;
            bus.err    <= (wacc && !w_in) || (racc && !r_in);
            if (racc) bus.q <= rdata;
            if (!idle) begin
                cnt   <= cnt == LAST ? '0 : cnt + 1'b1;
                state <= cnt == LAST ? IDLE : CLEAR;
            end else if (bus.clr) begin
                cnt   <= '0;
                state <= CLEAR;
            end
        end
    end
endmodule

// File: tb/tb_memory_data_be.sv
// tb_memory_data_be: directed checks on a 32-bit/R=100/zero-enabled instance
// and an 8-bit/R=128/plain instance sharing one clock and reset.
module tb_memory_data_be;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    memory_data_be_if #(.A(7), .D(32)) b0();
    memory_data_be_if #(.A(7), .D(8))  b1();

    memory_data_be #(.A(7), .D(32), .R(100), .ZERO_EN(1'b1)) u0(.clk(clk), .rst(rst), .bus(b0));
    memory_data_be #(.A(7), .D(8),  .R(128), .ZERO_EN(1'b0)) u1(.clk(clk), .rst(rst), .bus(b1));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic clr, input logic we, input logic [6:0] wa,
                          input logic [31:0] wd, input logic [3:0] be,
                          input logic re, input logic [6:0] ra);
        b0.clr = clr; b0.we = we; b0.waddr = wa; b0.wdata = wd; b0.wbe = be;
        b0.re = re; b0.raddr = ra;
    endtask

    task automatic drive1(input logic we, input logic [6:0] wa, input logic [7:0] wd,
                          input logic re, input logic [6:0] ra);
        b1.clr = 1'b0; b1.we = we; b1.waddr = wa; b1.wdata = wd; b1.wbe = 1'b1;
        b1.re = re; b1.raddr = ra;
    endtask

    task automatic test_reset();
        int n0 = 0;
        int n1 = 0;
        drive0(0, 0, 0, 0, 0, 0, 0);
        drive1(0, 0, 0, 0, 0);
        rst = 1'b1;
        cyc(); cyc();
        checks++;
        if (b0.busy !== 1'b1 || b0.q !== 32'h0 || b0.rvalid !== 1'b0 || b0.err !== 1'b0) begin
            failures++;
            $display("FAIL reset_u0 busy=%b q=%h rvalid=%b err=%b required busy=1 q=0 rvalid=0 err=0",
                     b0.busy, b0.q, b0.rvalid, b0.err);
        end
        checks++;
        if (b1.busy !== 1'b1 || b1.q !== 8'h0 || b1.rvalid !== 1'b0 || b1.err !== 1'b0) begin
            failures++;
            $display("FAIL reset_u1 busy=%b q=%h rvalid=%b err=%b required busy=1 q=0 rvalid=0 err=0",
                     b1.busy, b1.q, b1.rvalid, b1.err);
        end
        rst = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            cyc();
            if (b0.busy === 1'b0 && n0 == 0) n0 = k;
            if (b1.busy === 1'b0 && n1 == 0) n1 = k;
            if (n0 != 0 && n1 != 0) break;
        end
        checks++;
        if (n0 != 100) begin
            failures++;
            $display("FAIL busy_window_u0 edges=%0d required=100", n0);
        end
        checks++;
        if (n1 != 128) begin
            failures++;
            $display("FAIL busy_window_u1 edges=%0d required=128", n1);
        end
    endtask

    task automatic test_read_cleared();
        for (int a = 0; a < 128; a++) begin
            drive1(0, 0, 0, 1, 7'(a));
            cyc();
            checks++;
            if (b1.q !== 8'h0 || b1.rvalid !== 1'b1) begin
                failures++;
                $display("FAIL cleared_read addr=%0d q=%h rvalid=%b required q=00 rvalid=1", a, b1.q, b1.rvalid);
            end
        end
        drive1(0, 0, 0, 0, 0);
        cyc();
        checks++;
        if (b1.rvalid !== 1'b0) begin
            failures++;
            $display("FAIL rvalid_drop rvalid=%b required=0", b1.rvalid);
        end
    endtask

    task automatic test_byte_enable();
        drive0(0, 1, 5, 32'hAABBCCDD, 4'b1111, 0, 0); cyc();
        drive0(0, 1, 5, 32'h11223344, 4'b0101, 0, 0); cyc();
        drive0(0, 0, 0, 0, 0, 1, 5); cyc();
        checks++;
        if (b0.q !== 32'hAA22CC44 || b0.rvalid !== 1'b1 || b0.err !== 1'b0) begin
            failures++;
            $display("FAIL byte_enable q=%h rvalid=%b err=%b required q=aa22cc44 rvalid=1 err=0",
                     b0.q, b0.rvalid, b0.err);
        end
        drive0(0, 1, 5, 32'hFFFFFFFF, 4'b0000, 0, 0); cyc();
        drive0(0, 0, 0, 0, 0, 1, 5); cyc();
        checks++;
        if (b0.q !== 32'hAA22CC44) begin
            failures++;
            $display("FAIL wbe_zero_noop q=%h required=aa22cc44", b0.q);
        end
    endtask

    task automatic test_zero_addr();
        drive0(0, 1, 0, 32'h000000FF, 4'b0001, 0, 0);
        drive1(1, 0, 8'hFF, 0, 0);
        cyc();
        drive0(0, 0, 0, 0, 0, 1, 0);
        drive1(0, 0, 0, 1, 0);
        cyc();
        checks++;
        if (b0.q !== 32'h0 || b0.rvalid !== 1'b1) begin
            failures++;
            $display("FAIL zero_en_addr0 q=%h rvalid=%b required q=00000000 rvalid=1", b0.q, b0.rvalid);
        end
        checks++;
        if (b1.q !== 8'hFF) begin
            failures++;
            $display("FAIL plain_addr0 q=%h required=ff", b1.q);
        end
        drive1(0, 0, 0, 0, 0);
    endtask

    task automatic test_forward();
        drive0(0, 1, 9, 32'h12345678, 4'b0011, 1, 9); cyc();
        checks++;
        if (b0.q !== 32'h00005678 || b0.rvalid !== 1'b1) begin
            failures++;
            $display("FAIL forward q=%h rvalid=%b required q=00005678 rvalid=1", b0.q, b0.rvalid);
        end
        drive0(0, 0, 0, 0, 0, 1, 9); cyc();
        checks++;
        if (b0.q !== 32'h00005678) begin
            failures++;
            $display("FAIL forward_stored q=%h required=00005678", b0.q);
        end
    endtask

    task automatic test_out_of_range();
        drive0(0, 1, 120, 32'hDEADBEEF, 4'b1111, 0, 0); cyc();
        checks++;
        if (b0.err !== 1'b1) begin
            failures++;
            $display("FAIL oor_write_err err=%b required=1", b0.err);
        end
        drive0(0, 1, 99, 32'hCAFEF00D, 4'b1111, 0, 0); cyc();
        checks++;
        if (b0.err !== 1'b0) begin
            failures++;
            $display("FAIL last_entry_err err=%b required=0", b0.err);
        end
        drive0(0, 0, 0, 0, 0, 1, 99); cyc();
        checks++;
        if (b0.q !== 32'hCAFEF00D || b0.err !== 1'b0) begin
            failures++;
            $display("FAIL last_entry_read q=%h err=%b required q=cafef00d err=0", b0.q, b0.err);
        end
        drive0(0, 0, 0, 0, 0, 1, 120); cyc();
        checks++;
        if (b0.q !== 32'h0 || b0.rvalid !== 1'b1 || b0.err !== 1'b1) begin
            failures++;
            $display("FAIL oor_read q=%h rvalid=%b err=%b required q=0 rvalid=1 err=1", b0.q, b0.rvalid, b0.err);
        end
        drive0(0, 0, 0, 0, 0, 1, 100); cyc();
        checks++;
        if (b0.err !== 1'b1) begin
            failures++;
            $display("FAIL oor_read_boundary err=%b required=1", b0.err);
        end
        drive0(0, 0, 0, 0, 0, 0, 0); cyc();
        checks++;
        if (b0.err !== 1'b0) begin
            failures++;
            $display("FAIL err_pulse err=%b required=0", b0.err);
        end
    endtask

    task automatic test_clear();
        int n = 0;
        logic bad = 1'b0;
        drive0(1, 1, 3, 32'h0BADF00D, 4'b1111, 1, 3); cyc();
        checks++;
        if (b0.busy !== 1'b1 || b0.q !== 32'h0BADF00D || b0.rvalid !== 1'b1) begin
            failures++;
            $display("FAIL clr_cycle busy=%b q=%h rvalid=%b required busy=1 q=0badf00d rvalid=1",
                     b0.busy, b0.q, b0.rvalid);
        end
        for (int k = 1; k <= 200; k++) begin
            drive0(1, 1, 3, 32'h55555555, 4'b1111, 1, 7'(k % 128));
            cyc();
            if (b0.rvalid !== 1'b0 || b0.err !== 1'b0 || b0.q !== 32'h0BADF00D) bad = 1'b1;
            if (b0.busy === 1'b0) begin n = k; break; end
        end
        checks++;
        if (n != 100) begin
            failures++;
            $display("FAIL clr_busy_window edges=%0d required=100", n);
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL busy_ignores_port saw rvalid/err/q change during clear, required rvalid=0 err=0 q held");
        end
        drive0(0, 0, 0, 0, 0, 1, 3); cyc();
        checks++;
        if (b0.q !== 32'h0 || b0.rvalid !== 1'b1) begin
            failures++;
            $display("FAIL after_clear_addr3 q=%h rvalid=%b required q=0 rvalid=1", b0.q, b0.rvalid);
        end
        drive0(0, 0, 0, 0, 0, 1, 5); cyc();
        checks++;
        if (b0.q !== 32'h0) begin
            failures++;
            $display("FAIL after_clear_addr5 q=%h required=0", b0.q);
        end
    endtask

    task automatic test_rst_mid_clear();
        int n = 0;
        drive0(1, 0, 0, 0, 0, 0, 0); cyc();
        drive0(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 30; k++) cyc();
        rst = 1'b1; cyc();
        rst = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            cyc();
            if (b0.busy === 1'b0) begin n = k; break; end
        end
        checks++;
        if (n != 100) begin
            failures++;
            $display("FAIL rst_mid_clear edges=%0d required=100", n);
        end
    endtask

    initial begin
        test_reset();
        test_read_cleared();
        test_byte_enable();
        test_zero_addr();
        test_forward();
        test_out_of_range();
        test_clear();
        test_rst_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
